// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller reader.
// Button indices give the serial bit position of each button within the frame.
package snes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_CLK_LO,
      ST_CLK_HI,
      ST_DONE
   } state_t;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_poll_timer.sv
// Free-running poll-rate counter, 0..POLL_CYCLES-1.
// tick is high during the final count, i.e. on the cycle the counter wraps.
module snes_poll_timer #(
   parameter int POLL_CYCLES = 833333
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(POLL_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/snes_decoder.sv
// Console-side SNES controller reader: drives latch/clock strobes, samples the
// active-low serial line and publishes an active-high button word with valid.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for poll tick or poll_req; busy low
// ST_LATCH  | latch high for two half-periods, serial clock held high
// ST_CLK_LO | serial clock low; sample data on the last cycle
// ST_CLK_HI | serial clock high; advance to next bit or finish
// ST_DONE   | one cycle: buttons updated, valid high
module snes_decoder
   import snes_pkg::*;
#(
   parameter int NUM_BITS    = 16,
   parameter int HALF_CYCLES = 300,
   parameter int POLL_CYCLES = 833333
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                poll_req,
   input  logic                snes_data,
   output logic                snes_latch,
   output logic                snes_clk,
   output logic [NUM_BITS-1:0] buttons,
   output logic                valid,
   output logic                busy
);

   localparam int PW = $clog2(2 * HALF_CYCLES);
   localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   state_t              state;
   logic                sync_1;
   logic                sync_2;
   logic [PW-1:0]       phase;
   logic [BW-1:0]       bit_cnt;
   logic [NUM_BITS-1:0] shift;
   logic                tick;
   logic                trigger;

   snes_poll_timer #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   assign trigger = tick | poll_req;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         sync_1     <= 1'b1;
         sync_2     <= 1'b1;
         phase      <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         snes_latch <= 1'b0;
         snes_clk   <= 1'b1;
         buttons    <= '0;
         valid      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         sync_1 <= snes_data;
         sync_2 <= sync_1;
         valid  <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Triggers arriving in any other state are simply ignored.
               if (trigger) begin
                  state      <= ST_LATCH;
                  snes_latch <= 1'b1;
                  busy       <= 1'b1;
                  phase      <= PW'(2 * HALF_CYCLES - 1);
                  bit_cnt    <= '0;
                  shift      <= '0;
               end
            end
            ST_LATCH: begin
               if (phase == '0) begin
                  state      <= ST_CLK_LO;
                  snes_latch <= 1'b0;
                  snes_clk   <= 1'b0;
                  phase      <= PW'(HALF_CYCLES - 1);
               end else begin
                  phase <= phase - PW'(1);
               end
            end
            ST_CLK_LO: begin
               if (phase == '0) begin
                  shift[bit_cnt] <= ~sync_2;
                  state          <= ST_CLK_HI;
                  snes_clk       <= 1'b1;
                  phase          <= PW'(HALF_CYCLES - 1);
               end else begin
                  phase <= phase - PW'(1);
               end
            end
            ST_CLK_HI: begin
               if (phase == '0) begin
                  if (bit_cnt == BW'(NUM_BITS - 1)) begin
                     state   <= ST_DONE;
                     buttons <= shift;
                     valid   <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt + BW'(1);
                     state    <= ST_CLK_LO;
                     snes_clk <= 1'b0;
                     phase    <= PW'(HALF_CYCLES - 1);
                  end
               end else begin
                  phase <= phase - PW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/snes_decoder.md
Name: snes_decoder

Overview:
- Console-side reader for the SNES controller serial protocol; the host counterpart of our controller-side encoder.
- Generates the latch and serial clock strobes and samples the active-low serial data line.
- Presents a registered, active-high button word with a one-cycle valid pulse.
- Polls automatically at a fixed rate, or on request from game logic.

Parameters:
- NUM_BITS, 16, serial bits read per frame (12 buttons + 4 trailing ones).
- HALF_CYCLES, 300, system clocks per half serial-clock period (6 us at 50 MHz); must be >= 4.
- POLL_CYCLES, 833333, system clocks between automatic polls (60 Hz at 50 MHz); must exceed frame length.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- poll_req  in  1  single-cycle request for an immediate poll.
- snes_data  in  1  serial data from controller, active-low (0 = pressed), asynchronous.
- snes_latch  out  1  latch strobe to controller, active-high.
- snes_clk  out  1  serial clock to controller, idles high.
- buttons  out  NUM_BITS  last captured frame, active-high (1 = pressed); bit i = i-th serial bit.
- valid  out  1  one-cycle pulse when buttons updates.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: snes_latch=0, snes_clk=1, buttons=0, valid=0, busy=0, FSM=IDLE, poll counter=0, bit counter=0, synchronizer flops=1.
- snes_data passes through a 2-flop synchronizer before use. All outputs are registered.
- Poll counter counts 0..POLL_CYCLES-1 and wraps. Its tick fires on wrap.
- Trigger = tick OR poll_req.
  - A trigger seen outside IDLE is dropped, not queued.
  - A tick and a poll_req in the same cycle start a single frame.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
- IDLE: waits for a trigger; busy=0.
  - On a trigger: LATCH, and the bit counter and shift register clear.
- LATCH: snes_latch=1, snes_clk=1 for 2*HALF_CYCLES cycles, then CLK_LO.
- CLK_LO: snes_clk=0 for HALF_CYCLES cycles.
  - On the last cycle, the inverted synchronized data shifts into shift-register position [bit counter].
  - Then CLK_HI.
- CLK_HI: snes_clk=1 for HALF_CYCLES cycles.
  - If the bit counter = NUM_BITS-1: DONE.
  - Otherwise: increment the bit counter, then CLK_LO.
- DONE: one cycle; buttons <= shift register, valid=1; then IDLE.
- busy=1 in LATCH, CLK_LO, CLK_HI and DONE.
- Trigger-to-valid latency: 2*HALF_CYCLES*(NUM_BITS+1)+1 cycles after the trigger cycle. For HALF_CYCLES=4, NUM_BITS=16 this is 137.
- Waveform order: snes_latch rises the cycle after the trigger. snes_clk never toggles during LATCH.
- buttons holds its value between frames. It changes only in DONE.
- Disconnected controller: the line floats high, so all bits read 0 (no buttons). No error flag.
- Reset mid-frame: next cycle the FSM returns to IDLE and all outputs and counters take reset values. The partial frame is discarded; buttons is not updated.
- The poll counter keeps running during a frame. A tick that lands during a frame is dropped.

Decomposition:
- snes_pkg holds:
  - the FSM state enum;
  - button index constants: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
- One sub-module, snes_poll_timer: the poll counter and tick generator, parameterized by POLL_CYCLES, with clock and reset.
- Synchronizer, phase counter and shift register stay in snes_decoder.

Test Plan:
- Reset then idle (HALF_CYCLES=4, POLL_CYCLES=1000) -> snes_clk=1, snes_latch=0, buttons=0. First valid occurs exactly 137 cycles after the first tick.
- poll_req pulse; controller model drives serial 0,1,1,1,1,1,1,1,0,1,... (B and A pressed) -> snes_latch high 8 cycles, then 16 clock lows of 4 cycles. valid pulses once with buttons=16'h0101.
- snes_data held 1 throughout -> buttons=16'h0000. Held 0 throughout -> buttons=16'hFFFF.
- poll_req asserted mid-frame and again in DONE -> no second frame starts. busy is continuous, then low, and exactly one valid pulse occurs.
- reset asserted during bit 7 CLK_LO -> next cycle snes_clk=1, snes_latch=0, busy=0, valid=0. The buttons previous value (e.g. 16'h0101) is cleared to 0 and no valid pulse occurs.
- poll_req coincident with the timer tick -> exactly one frame and one valid pulse.
